// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmit framer. A byte and its externally generated parity bit are
// taken through a valid/ready handshake and shifted out on tx_out as:
//   start (0), 8 data bits LSB-first, optional parity slot, 1 or 2 stop (1).
// Every serial bit lasts CLKS_PER_BIT clocks, timed by an internal divider.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   data_in      byte to transmit
//   parity_in    parity bit for data_in, sent unmodified in the parity slot
//   parity_type  01 odd / 10 even -> parity slot sent; 00 / 11 -> no slot
//   stop_bits    0: one stop bit, 1: two stop bits
//   in_valid     upstream offers a byte
//   in_ready     block can accept (IDLE and not in reset)
//   tx_out       registered serial line, idle high
//   busy         registered, high while a frame is on the line
//   tx_done      registered one-cycle pulse on the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [1:0]       ptype_q;
  logic             stop2_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic bit_end_d;
  logic has_parity_d;

  assign bit_end_d    = (div_q == DIV_LAST);
  assign has_parity_d = (ptype_q == 2'b01) || (ptype_q == 2'b10);

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

  // tx_q is loaded with the value belonging to the state being entered, so
  // the line changes on the same edge as the state and needs no output decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'd0;
      parity_q  <= 1'b0;
      ptype_q   <= 2'b00;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        // rst_n is high here, so in_ready reduces to the IDLE state check
        if (in_valid) begin
          data_q    <= data_in;
          parity_q  <= parity_in;
          ptype_q   <= parity_type;
          stop2_q   <= stop_bits;
          div_q     <= '0;
          bit_cnt_q <= 3'd0;
          state_q   <= S_START;
          tx_q      <= 1'b0;
          busy_q    <= 1'b1;
        end
      end else if (!bit_end_d) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        if (state_q == S_START) begin
          state_q <= S_DATA;
          tx_q    <= data_q[0];
        end else if (state_q == S_DATA) begin
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            tx_q      <= data_q[bit_cnt_q + 3'd1];
          end else begin
            // bit counter is reused to count stop bits, so it restarts here
            bit_cnt_q <= 3'd0;
            if (has_parity_d) begin
              state_q <= S_PARITY;
              tx_q    <= parity_q;
            end else begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
          end
        end else if (state_q == S_PARITY) begin
          state_q <= S_STOP;
          tx_q    <= 1'b1;
        end else if (state_q == S_STOP) begin
          if (stop2_q && (bit_cnt_q == 3'd0)) begin
            bit_cnt_q <= 3'd1;
          end else begin
            bit_cnt_q <= 3'd0;
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          // unreachable encodings fall back to a clean idle line
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Directed plus randomized bench for uart_tx_frame with CLKS_PER_BIT = 4.
// The expected line for each frame is built as a list of serial bits from
// the framing rules, then every clock of every bit is compared.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       parity_in = 1'b0;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_out;
  logic       busy;
  logic       tx_done;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .parity_in   (parity_in),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_out      (tx_out),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", tx_out, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", tx_done, 1'b0);
      chk("idle_ready", in_ready, 1'b1);
    end
  endtask

  // Called just after a negedge with the DUT idle. Offers one byte, checks
  // every clock of the frame and the tx_done cycle that follows it.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] pt,
                            input logic sb, input bit hold_valid, input bit mutate);
    logic exp_bits[$];
    int   nbits;
    chk("ready_before_accept", in_ready, 1'b1);
    data_in     = d;
    parity_in   = p;
    parity_type = pt;
    stop_bits   = sb;
    in_valid    = 1'b1;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pt == 2'b01 || pt == 2'b10) exp_bits.push_back(p);
    exp_bits.push_back(1'b1);
    if (sb) exp_bits.push_back(1'b1);
    nbits = exp_bits.size();
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) in_valid = hold_valid;
        if (mutate && b == 3 && c == 1) begin
          data_in     = 8'($urandom);
          parity_in   = 1'($urandom);
          parity_type = 2'($urandom);
          stop_bits   = 1'($urandom);
        end
        chk($sformatf("tx_bit%0d_clk%0d", b, c), tx_out, exp_bits[b]);
        chk($sformatf("busy_bit%0d", b), busy, 1'b1);
        chk($sformatf("done_bit%0d", b), tx_done, 1'b0);
        chk($sformatf("ready_bit%0d", b), in_ready, 1'b0);
      end
    end
    @(negedge clk);
    chk("done_pulse", tx_done, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("tx_after", tx_out, 1'b1);
    chk("ready_after", in_ready, 1'b1);
    $display("frame data=%02h par=%b ptype=%b stop2=%b cycles=%0d hold=%0d mutate=%0d errors=%0d",
             d, p, pt, sb, nbits * C, hold_valid, mutate, n_bad);
  endtask

  initial begin
    bit hold;
    // reset held with in_valid high: nothing may start
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", tx_done, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle_cycles(2);
    $display("reset check done errors=%0d", n_bad);

    // even parity, one stop: 0,1,0,1,0,0,1,0,1,0,1 -> 44 cycles
    send_frame(8'hA5, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    // no parity, two stops: 0,0,0,1,1,1,1,0,0,1,1 -> 44 cycles
    send_frame(8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    // odd parity back-to-back: second byte taken in the tx_done cycle
    send_frame(8'h01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    // inputs (and in_valid) change during DATA: latched values must win
    send_frame(8'h96, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    idle_cycles(1);

    // mid-frame reset during data bit 3
    data_in     = 8'h5A;
    parity_in   = 1'b1;
    parity_type = 2'b01;
    stop_bits   = 1'b0;
    in_valid    = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("pre_abort_bit3", tx_out, 1'b1);
    chk("pre_abort_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx_out, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", tx_done, 1'b0);
    chk("abort_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    idle_cycles(50);
    $display("mid-frame reset check done errors=%0d", n_bad);
    send_frame(8'h55, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);

    // randomized frames, random gaps and back-to-back runs
    for (int k = 0; k < 10; k++) begin
      hold = (k != 9) && ($urandom_range(0, 1) == 1);
      send_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 hold, ($urandom_range(0, 3) == 0));
      if (!hold) idle_cycles($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
